// File: rtl/apb_slave_mem_responder.sv
// apb_slave_mem_responder
//   APB4 completer backed by an internal word memory. One instance serves one
//   bit of pselx. Supports byte strobes, programmable wait states (sampled in
//   the setup phase), PSLVERR for out-of-window, misaligned and (optionally)
//   non-secure accesses, a sticky protocol-violation flag and a 16-bit
//   completed-transfer counter.
//
// Ports
//   pclk, preset           clock; asynchronous active-high reset
//   pselx                  one-hot slave selects, bit SLAVE_ID is ours
//   penable, pwrite        access phase, direction (1 = write)
//   paddr, pwdata, pstrb   byte address, write data, write byte lanes
//   pprot                  protection; only bit 1 (non-secure) is used
//   cfg_wait_states        wait cycles for the transfer being set up
//   pready, prdata, pslverr  registered completion response
//   proto_err              sticky protocol-violation flag
//   xfer_count             completed transfers, wraps at 0xFFFF
module apb_slave_mem_responder #(
  parameter int                       ADDRESS_WIDTH     = 32,
  parameter int                       DATA_WIDTH        = 32,
  parameter int                       NO_OF_SLAVES      = 4,
  parameter int                       SLAVE_ID          = 0,
  parameter int                       SLAVE_MEMORY_SIZE = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR         = '0,
  parameter int                       SECURE_ONLY       = 0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NO_OF_SLAVES-1:0]   pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                cfg_wait_states,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  output logic                      proto_err,
  output logic [15:0]               xfer_count
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int ADDR_LSB  = $clog2(STRB_W);
  localparam int MEM_DEPTH = SLAVE_MEMORY_SIZE * 1024 / STRB_W;
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(SLAVE_MEMORY_SIZE) * 64'd1024;
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(STRB_W - 1);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  // Offset is unsigned, so an address below BASE_ADDR wraps to a huge value
  // and lands outside the window.
  function automatic logic access_err(input logic [ADDRESS_WIDTH-1:0] addr,
                                      input logic                     nonsecure);
    return (64'(addr - BASE_ADDR) >= MEM_BYTES) ||
           ((addr & ALIGN_MASK) != '0) ||
           ((SECURE_ONLY != 0) && nonsecure);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDRESS_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> ADDR_LSB);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  proto_err_q, proto_err_d;
  logic [15:0]           xfer_count_q, xfer_count_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  err_q, err_d;

  logic                  sel;
  logic                  setup_err;
  logic [IDX_W-1:0]      setup_idx;
  logic                  mem_we;
  logic                  unused_prot;

  assign sel         = pselx[SLAVE_ID];
  assign setup_err   = access_err(paddr, pprot[1]);
  assign setup_idx   = word_idx(paddr);
  assign unused_prot = ^{pprot[2], pprot[0]};

  assign pready     = pready_q;
  assign prdata     = prdata_q;
  assign pslverr    = pslverr_q;
  assign proto_err  = proto_err_q;
  assign xfer_count = xfer_count_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    idx_d        = idx_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    err_d        = err_q;
    proto_err_d  = proto_err_q;
    xfer_count_d = xfer_count_q;
    // Response registers are single-cycle pulses; they clear unless set below.
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = '0;
    mem_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel && !penable) begin
          idx_d      = setup_idx;
          write_d    = pwrite;
          wdata_d    = pwdata;
          strb_d     = pstrb;
          err_d      = setup_err;
          wait_cnt_d = cfg_wait_states;
          state_d    = ST_ACCESS;
          if (cfg_wait_states == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (setup_err || pwrite) ? '0 : mem[setup_idx];
          end
        end else if (sel && penable) begin
          proto_err_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (pready_q) begin
          mem_we       = write_q && !err_q;
          xfer_count_d = xfer_count_q + 16'd1;
          state_d      = ST_IDLE;
        end else if (!(sel && penable)) begin
          // Abort before completion; a setup phase seen here is dropped.
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (err_q || write_q) ? '0 : mem[idx_q];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      prdata_q     <= '0;
      proto_err_q  <= 1'b0;
      xfer_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      prdata_q     <= prdata_d;
      proto_err_q  <= proto_err_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Latched transfer attributes are only meaningful while in ACCESS.
  always_ff @(posedge pclk) begin
    idx_q   <= idx_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
    err_q   <= err_d;
  end

  always_ff @(posedge pclk) begin
    if (mem_we) mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, strb_q);
  end

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
module tb_apb_slave_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SID  = 2;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [3:0]  pselx = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic [3:0]  cfg_wait_states = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        proto_err;
  logic [15:0] xfer_count;

  always #5 pclk = ~pclk;

  apb_slave_mem_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(4), .SLAVE_ID(SID),
    .SLAVE_MEMORY_SIZE(12), .BASE_ADDR(BASE), .SECURE_ONLY(1)
  ) dut (
    .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .cfg_wait_states(cfg_wait_states), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .proto_err(proto_err),
    .xfer_count(xfer_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [logic [31:0]];
  logic [15:0] exp_count = 16'd0;

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] pr);
    logic [31:0] off;
    off = a - BASE;
    return (off >= 32'd12288) || (a[1:0] != 2'b00) || pr[1];
  endfunction

  // Record the expected response of a transfer that will complete, and apply
  // its effect to the reference memory.
  task automatic push_exp(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr);
    exp_t        e;
    logic [31:0] w;
    e.err      = exp_err(a, pr);
    e.chk_data = e.err || !wr;
    e.data     = 32'd0;
    if (!e.err && !wr) e.data = model[a];
    if (!e.err && wr) begin
      w = model.exists(a) ? model[a] : 32'd0;
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      model[a] = w;
    end
    sb.push_back(e);
    exp_count = exp_count + 16'd1;
  endtask

  task automatic idle_bus();
    pselx   = '0;
    penable = 1'b0;
  endtask

  task automatic setup_phase(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [2:0] pr, input logic [3:0] ws);
    pselx           = '0;
    pselx[SID]      = 1'b1;
    penable         = 1'b0;
    paddr           = a;
    pwrite          = wr;
    pwdata          = wd;
    pstrb           = st;
    pprot           = pr;
    cfg_wait_states = ws;
  endtask

  // Complete transfer; called and returns just after a rising edge.
  task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input logic [3:0] ws);
    int cyc;
    push_exp(a, wr, wd, st, pr);
    setup_phase(a, wr, wd, st, pr, ws);
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge pclk);
    while (!pready && cyc < 20) begin
      @(negedge pclk);
      cyc++;
    end
    check("access_cycles", 32'(cyc), 32'(ws) + 32'd1);
    @(posedge pclk); #1;
    idle_bus();
    check("pready_cleared", 32'(pready), 32'd0);
    check("prdata_cleared", prdata, 32'd0);
    check("xfer_count", 32'(xfer_count), 32'(exp_count));
  endtask

  // Scoreboard: every completion is matched against the oldest expectation.
  always @(negedge pclk) begin
    exp_t e;
    if (!preset && pready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pslverr", 32'(pslverr), 32'(e.err));
        if (e.chk_data) check("prdata", prdata, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Full word, zero waits, then read back.
    apb_xfer(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0);
    check("first_count", 32'(xfer_count), 32'd1);
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    // Byte strobes; read with all strobes set must ignore them.
    apb_xfer(BASE + 32'h10, 1'b1, 32'h11223344, 4'b0101, 3'b000, 4'd0);
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    check("strobe_model", model[BASE + 32'h10], 32'hDE22BE44);
    apb_xfer(BASE, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 4'd1);
    // Wait states on a read.
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 4'd3);
    // Error cases.
    apb_xfer(BASE + 32'd12288, 1'b1, 32'h12345678, 4'hF, 3'b000, 4'd0);
    apb_xfer(BASE, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    apb_xfer(BASE + 32'h2, 1'b1, 32'h0BADF00D, 4'hF, 3'b000, 4'd2);
    apb_xfer(BASE - 32'h4, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    apb_xfer(BASE, 1'b1, 32'h0BADBAD0, 4'hF, 3'b010, 4'd0);
    apb_xfer(BASE, 1'b0, 32'h0, 4'hF, 3'b010, 4'd1);
    apb_xfer(BASE + 32'd12284, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b101, 4'd0);
    apb_xfer(BASE + 32'd12284, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    // Zero strobes: no change, no error.
    apb_xfer(BASE, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, 4'd0);
    apb_xfer(BASE, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);

    // Protocol violation: penable dropped in access cycle 2 of a 2-wait write.
    setup_phase(BASE + 32'h10, 1'b1, 32'h55555555, 4'hF, 3'b000, 4'd2);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("viol_c1_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b0;
    @(negedge pclk);
    check("viol_c2_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    idle_bus();
    @(negedge pclk);
    check("viol_proto_err", 32'(proto_err), 32'd1);
    check("viol_pready", 32'(pready), 32'd0);
    check("viol_count", 32'(xfer_count), 32'(exp_count));
    @(posedge pclk); #1;
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    check("proto_err_sticky", 32'(proto_err), 32'd1);

    // Reset during a wait state of a write.
    setup_phase(BASE + 32'h10, 1'b1, 32'h00000000, 4'hF, 3'b000, 4'd5);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk);
    @(negedge pclk); #2;
    preset = 1'b1;
    idle_bus();
    #1;
    check("rstw_pready", 32'(pready), 32'd0);
    check("rstw_pslverr", 32'(pslverr), 32'd0);
    check("rstw_prdata", prdata, 32'd0);
    check("rstw_count", 32'(xfer_count), 32'd0);
    check("rstw_proto_err", 32'(proto_err), 32'd0);
    exp_count = 16'd0;
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);

    // Reset while a read response is being presented.
    push_exp(BASE, 1'b0, 32'h0, 4'hF, 3'b000);
    setup_phase(BASE, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("rstr_pre_pready", 32'(pready), 32'd1);
    #2;
    preset = 1'b1;
    idle_bus();
    #1;
    check("rstr_pready", 32'(pready), 32'd0);
    check("rstr_prdata", prdata, 32'd0);
    check("rstr_count", 32'(xfer_count), 32'd0);
    exp_count = 16'd0;
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Select with penable while idle is a violation.
    setup_phase(BASE, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    penable = 1'b1;
    @(posedge pclk); #1;
    idle_bus();
    @(negedge pclk);
    check("idle_viol_proto_err", 32'(proto_err), 32'd1);
    check("idle_viol_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    apb_xfer(BASE, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);

    // Counter wrap, starting just below the top of the range.
    force dut.xfer_count_q = 16'hFFFE;
    @(posedge pclk); #1;
    release dut.xfer_count_q;
    exp_count = 16'hFFFE;
    apb_xfer(BASE, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    check("count_top", 32'(xfer_count), 32'h0000FFFF);
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    check("count_wrap", 32'(xfer_count), 32'd0);

    repeat (2) @(posedge pclk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem_responder.md
Name: apb_slave_mem_responder

Overview:
- RTL APB4 completer (slave) with internal word memory. It consumes the bus the APB master drives.
- It is the DUT-side memory endpoint that the slave agent observes.
- One instance is used per slave select line. Its address window, memory size, byte strobes, wait states and PSLVERR follow the team's global APB parameters.
- It drives PREADY, PRDATA and PSLVERR for its select bit and tracks protocol violations.

Parameters:
- ADDRESS_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32.
- NO_OF_SLAVES, 4, width of pselx.
- SLAVE_ID, 0, index of the pselx bit this instance responds to.
- SLAVE_MEMORY_SIZE, 12, memory size in KB. MEM_DEPTH = SLAVE_MEMORY_SIZE*1024/(DATA_WIDTH/8) words (3072 by default).
- BASE_ADDR, 0, byte address of word 0.
- SECURE_ONLY, 0, when 1, a non-secure access (pprot[1]=1) is an error.

Ports:
- pclk  in  1  bus clock; all state updates on rising edge.
- preset  in  1  reset, asynchronous, active-high.
- pselx  in  NO_OF_SLAVES  one-hot slave selects; only bit SLAVE_ID is used.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDRESS_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte-lane enables.
- pprot  in  3  protection type.
- cfg_wait_states  in  4  wait cycles to insert; sampled in the setup phase.
- pready  out  1  transfer completion.
- prdata  out  DATA_WIDTH  read data, valid when pready=1.
- pslverr  out  1  error response, valid when pready=1.
- proto_err  out  1  sticky protocol-violation flag.
- xfer_count  out  16  completed-transfer counter, wraps at 0xFFFF to 0.

Behaviour:
- Clock is pclk. Reset is preset, asynchronous, active-high.
- While preset=1: pready=0, prdata=0, pslverr=0, proto_err=0, xfer_count=0, state=IDLE. Memory contents are not reset (X until written).
- Reset mid-transfer aborts the transfer with no memory write.
- sel = pselx[SLAVE_ID].
- FSM states: IDLE, ACCESS.
- IDLE:
  - On sel=1 and penable=0 (setup phase): latch paddr, pwrite, pwdata, pstrb, pprot.
  - Load wait_cnt=cfg_wait_states and compute err.
  - Go to ACCESS.
  - If wait_cnt loads 0, the pready register is set on the same edge.
  - sel=1 with penable=1 in IDLE is a violation: set proto_err, stay in IDLE.
- ACCESS:
  - Requires sel=1 and penable=1 every cycle.
  - If wait_cnt!=0: decrement it, pready stays 0. pready is set on the edge where wait_cnt goes 1->0.
  - N wait states give pready=1 in access cycle N+1, counting the first penable cycle as cycle 1.
  - Completion cycle (pready=1): the memory write commits at the end of this cycle, when pwrite=1 and err=0.
  - xfer_count increments, including on error.
  - Next edge: clear pready, pslverr and prdata; return to IDLE.
  - Back-to-back transfers: a setup phase in the cycle after completion is accepted from IDLE.
- Violation in ACCESS before completion (sel=0 or penable=0):
  - Abort, no write, no count.
  - Set proto_err (sticky until reset), go to IDLE.
  - If that cycle is itself a new setup phase, it is not accepted; the master must re-issue.
- err = any of the following:
  - (paddr-BASE_ADDR) >= MEM_DEPTH*(DATA_WIDTH/8), with unsigned compare, so paddr<BASE_ADDR also errors.
  - paddr low log2(DATA_WIDTH/8) bits !=0 (misaligned).
  - SECURE_ONLY=1 and pprot[1]=1.
- On err: pslverr=1 and prdata=0 at completion; no memory write.
- Word index = (paddr-BASE_ADDR)>>log2(DATA_WIDTH/8).
- Write: only byte lanes with pstrb[i]=1 are updated. pstrb=0 on a write completes with no change and no error.
- Read: prdata is loaded from memory into the output register on the same edge that sets pready. pstrb is ignored on reads.
- pprot[0] and pprot[2] are ignored.

Test Plan:
- Full-word write: wait=0, write 0xDEADBEEF to BASE+0x10, pstrb=4'b1111 -> pready=1 in first access cycle, pslverr=0, xfer_count=1. Read same address -> prdata=0xDEADBEEF.
- Byte strobes: write 0x11223344, pstrb=4'b0101, to BASE+0x10 -> read returns 0xDE22BE44. Read issued with pstrb=4'b1111 -> still 0xDE22BE44, no error.
- Wait states: cfg_wait_states=3 on a read -> pready=0 for access cycles 1-3 and 1 in cycle 4. xfer_count increments exactly once.
- Error addresses: write to BASE+12288 -> pslverr=1, prdata=0; reading BASE+0 afterwards is unchanged. BASE+0x2 -> pslverr=1. With SECURE_ONLY=1 and pprot=3'b010 -> pslverr=1.
- Protocol violation: wait=2, penable dropped in access cycle 2 -> proto_err=1, no write, xfer_count unchanged. Next clean transfer completes normally; proto_err stays 1.
- Reset: preset pulsed during a wait state of a write -> pready/pslverr/prdata go 0 immediately without a clock, location keeps its prior value, xfer_count=0. Counter wrap: 65536 completions -> xfer_count=0.
